// File: rtl/micro_sequencer.sv
// Microprogram sequencer: holds the registered micro-PC, picks the next
// control-store address from the current microinstruction's next-state
// operation, and keeps a small return stack for microsubroutines.
// The stack is kept as a shift register with the top entry at index 0.
// This makes "top of stack" a fixed tap, so it never needs a variable index.
module micro_sequencer #(
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned STACK_DEPTH = 4,
    parameter int unsigned RESET_ADDR  = 0,
    parameter int unsigned FETCH_ADDR  = 1
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               hold,
    input  logic [3:0]                         ns_op,
    input  logic                               cond,
    input  logic [ADDR_W-1:0]                  cr_addr,
    input  logic [ADDR_W-1:0]                  enc_addr,
    output logic [ADDR_W-1:0]                  next_addr,
    output logic [ADDR_W-1:0]                  upc,
    output logic [$clog2(STACK_DEPTH+1)-1:0]   sp,
    output logic                               err_ovf,
    output logic                               err_unf,
    output logic                               err_op
);

    localparam int unsigned SP_W = $clog2(STACK_DEPTH + 1);

    localparam logic [ADDR_W-1:0] RST_A   = ADDR_W'(RESET_ADDR);
    localparam logic [ADDR_W-1:0] FETCH_A = ADDR_W'(FETCH_ADDR);
    localparam logic [SP_W-1:0]   SP_FULL = SP_W'(STACK_DEPTH);
    localparam logic [SP_W-1:0]   SP_ZERO = '0;

    localparam logic [3:0] OP_ENC    = 4'd0;
    localparam logic [3:0] OP_FETCH  = 4'd1;
    localparam logic [3:0] OP_JMP    = 4'd2;
    localparam logic [3:0] OP_INC    = 4'd3;
    localparam logic [3:0] OP_CJMP   = 4'd4;
    localparam logic [3:0] OP_CJMPN  = 4'd5;
    localparam logic [3:0] OP_CENC   = 4'd6;
    localparam logic [3:0] OP_CFETCH = 4'd7;
    localparam logic [3:0] OP_CALL   = 4'd8;
    localparam logic [3:0] OP_CCALL  = 4'd9;
    localparam logic [3:0] OP_RET    = 4'd10;
    localparam logic [3:0] OP_CRET   = 4'd11;
    localparam logic [3:0] OP_WAIT   = 4'd12;

    logic [ADDR_W-1:0] stack_q [STACK_DEPTH];
    logic [ADDR_W-1:0] inc;
    logic              push_req;
    logic              pop_req;
    logic              op_bad;
    logic              stk_full;
    logic              stk_empty;

    assign inc       = upc + ADDR_W'(1);
    assign stk_full  = (sp == SP_FULL);
    assign stk_empty = (sp == SP_ZERO);

    // Next-address decode and stack request; an empty-stack pop falls back to fetch.
    always_comb begin
        next_addr = inc;
        push_req  = 1'b0;
        pop_req   = 1'b0;
        op_bad    = 1'b0;
        case (ns_op)
            OP_ENC:    next_addr = enc_addr;
            OP_FETCH:  next_addr = FETCH_A;
            OP_JMP:    next_addr = cr_addr;
            OP_INC:    next_addr = inc;
            OP_CJMP:   if (cond)  next_addr = cr_addr;
            OP_CJMPN:  if (!cond) next_addr = cr_addr;
            OP_CENC:   if (cond)  next_addr = enc_addr;
            OP_CFETCH: if (cond)  next_addr = FETCH_A;
            OP_CALL: begin
                next_addr = cr_addr;
                push_req  = 1'b1;
            end
            OP_CCALL: begin
                if (cond) begin
                    next_addr = cr_addr;
                    push_req  = 1'b1;
                end
            end
            OP_RET:    pop_req = 1'b1;
            OP_CRET:   pop_req = cond;
            OP_WAIT:   if (!cond) next_addr = upc;
            default:   op_bad = 1'b1;
        endcase
        if (pop_req) begin
            next_addr = stk_empty ? FETCH_A : stack_q[0];
        end
    end

    // uPC, occupancy and sticky error flags; reset wins over hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            upc     <= RST_A;
            sp      <= SP_ZERO;
            err_ovf <= 1'b0;
            err_unf <= 1'b0;
            err_op  <= 1'b0;
        end else if (!hold) begin
            upc <= next_addr;
            if (push_req) begin
                if (stk_full) err_ovf <= 1'b1;
                else          sp      <= sp + SP_W'(1);
            end
            if (pop_req) begin
                if (stk_empty) err_unf <= 1'b1;
                else           sp      <= sp - SP_W'(1);
            end
            if (op_bad) err_op <= 1'b1;
        end
    end

    // Return-stack contents; a push onto a full stack is dropped without shifting.
    always_ff @(posedge clk) begin
        if (!reset && !hold) begin
            if (push_req && !stk_full) begin
                for (int i = 1; i < STACK_DEPTH; i++) begin
                    stack_q[i] <= stack_q[i-1];
                end
                stack_q[0] <= inc;
            end else if (pop_req && !stk_empty) begin
                for (int i = 0; i < STACK_DEPTH - 1; i++) begin
                    stack_q[i] <= stack_q[i+1];
                end
            end
        end
    end

endmodule

// File: tb/tb_micro_sequencer.sv
// Randomised and directed bench for micro_sequencer with a queue-based
// reference model and a decoupled scoreboard monitor.
module tb_micro_sequencer;

    localparam int DEPTH = 4;
    localparam logic [7:0] FETCH = 8'd1;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       hold = 1'b0;
    logic [3:0] ns_op = 4'd3;
    logic       cond = 1'b0;
    logic [7:0] cr_addr = '0;
    logic [7:0] enc_addr = '0;
    logic [7:0] next_addr;
    logic [7:0] upc;
    logic [2:0] sp;
    logic       err_ovf, err_unf, err_op;

    micro_sequencer #(.ADDR_W(8), .STACK_DEPTH(DEPTH), .RESET_ADDR(0), .FETCH_ADDR(1)) dut (
        .clk(clk), .reset(reset), .hold(hold), .ns_op(ns_op), .cond(cond),
        .cr_addr(cr_addr), .enc_addr(enc_addr), .next_addr(next_addr),
        .upc(upc), .sp(sp), .err_ovf(err_ovf), .err_unf(err_unf), .err_op(err_op)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         chk_na;
        logic [7:0] na;
        logic [7:0] upc;
        logic [2:0] sp;
        logic       ovf, unf, op;
    } exp_t;

    exp_t exp_q[$];
    int n_cmp = 0;
    int n_bad = 0;

    // reference model state
    logic [7:0] m_upc = '0;
    logic [7:0] m_stk[$];
    logic       m_ovf = 1'b0, m_unf = 1'b0, m_op = 1'b0;
    bit         m_known = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h at %0t", nm, act, req, $time);
        end
    endtask

    task automatic step(input bit r, input bit h, input logic [3:0] op, input bit c,
                        input logic [7:0] cr, input logic [7:0] en);
        exp_t e;
        logic [7:0] inc, na;
        bit psh, pp, bad;
        @(negedge clk);
        reset = r; hold = h; ns_op = op; cond = c; cr_addr = cr; enc_addr = en;
        inc = m_upc + 8'd1;
        na = inc; psh = 0; pp = 0; bad = 0;
        case (op)
            4'd0:  na = en;
            4'd1:  na = FETCH;
            4'd2:  na = cr;
            4'd3:  na = inc;
            4'd4:  na = c ? cr : inc;
            4'd5:  na = c ? inc : cr;
            4'd6:  na = c ? en : inc;
            4'd7:  na = c ? FETCH : inc;
            4'd8:  begin na = cr; psh = 1; end
            4'd9:  if (c) begin na = cr; psh = 1; end
            4'd10: pp = 1;
            4'd11: pp = c;
            4'd12: na = c ? inc : m_upc;
            default: bad = 1;
        endcase
        if (pp) na = (m_stk.size() == 0) ? FETCH : m_stk[0];
        e.chk_na = m_known;
        e.na = na;
        if (r) begin
            m_upc = 8'd0; m_stk.delete(); m_ovf = 0; m_unf = 0; m_op = 0; m_known = 1;
        end else if (!h) begin
            m_upc = na;
            if (psh) begin
                if (m_stk.size() == DEPTH) m_ovf = 1;
                else m_stk.push_front(inc);
            end
            if (pp) begin
                if (m_stk.size() == 0) m_unf = 1;
                else void'(m_stk.pop_front());
            end
            if (bad) m_op = 1;
        end
        e.upc = m_upc; e.sp = 3'(m_stk.size());
        e.ovf = m_ovf; e.unf = m_unf; e.op = m_op;
        exp_q.push_back(e);
    endtask

    // monitor: next_addr before the edge, registered state just after it
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q[0];
                if (e.chk_na) chk("next_addr", 32'(next_addr), 32'(e.na));
                @(posedge clk);
                #1;
                chk("upc", 32'(upc), 32'(e.upc));
                chk("sp", 32'(sp), 32'(e.sp));
                chk("err_ovf", 32'(err_ovf), 32'(e.ovf));
                chk("err_unf", 32'(err_unf), 32'(e.unf));
                chk("err_op", 32'(err_op), 32'(e.op));
                void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        // reset then idle
        step(1, 0, 4'd3, 0, 8'h00, 8'h00);
        step(1, 0, 4'd3, 0, 8'h00, 8'h00);
        repeat (3) step(0, 0, 4'd3, 0, 8'h00, 8'h00);
        // conditional branches
        step(0, 0, 4'd2, 0, 8'h05, 8'h00);
        step(0, 0, 4'd4, 1, 8'h40, 8'h00);
        step(0, 0, 4'd2, 0, 8'h05, 8'h00);
        step(0, 0, 4'd4, 0, 8'h40, 8'h00);
        step(0, 0, 4'd5, 0, 8'h40, 8'h00);
        // call/return nesting
        step(0, 0, 4'd2, 0, 8'h10, 8'h00);
        step(0, 0, 4'd8, 0, 8'h80, 8'h00);
        step(0, 0, 4'd8, 0, 8'h90, 8'h00);
        step(0, 0, 4'd10, 0, 8'h00, 8'h00);
        step(0, 0, 4'd10, 0, 8'h00, 8'h00);
        // stack boundaries
        for (int i = 0; i < 5; i++) step(0, 0, 4'd8, 0, 8'(8'h30 + 8'(i * 16)), 8'h00);
        for (int i = 0; i < 5; i++) step(0, 0, 4'd10, 0, 8'h00, 8'h00);
        // wait and hold
        step(0, 0, 4'd2, 0, 8'h22, 8'h00);
        repeat (3) step(0, 0, 4'd12, 0, 8'h00, 8'h00);
        step(0, 0, 4'd12, 1, 8'h00, 8'h00);
        step(0, 1, 4'd8, 0, 8'h55, 8'h00);
        step(0, 1, 4'd8, 0, 8'h55, 8'h00);
        // wrap, illegal op, reset under hold mid-subroutine
        step(0, 0, 4'd2, 0, 8'hFF, 8'h00);
        step(0, 0, 4'd3, 0, 8'h00, 8'h00);
        step(0, 0, 4'd14, 0, 8'h00, 8'h00);
        for (int i = 0; i < 3; i++) step(0, 0, 4'd8, 0, 8'(8'h60 + 8'(i)), 8'h00);
        step(1, 1, 4'd8, 0, 8'h77, 8'h00);
        step(0, 0, 4'd3, 0, 8'h00, 8'h00);
        // random traffic
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 10),
                 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                 8'($urandom), 8'($urandom));
        end
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d responses outstanding, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/micro_sequencer.md
Name: micro_sequencer

Overview:
- Parametrised microprogram sequencer for the control unit.
- Replaces the purely combinational next-state mux-select logic with a registered micro-PC (uPC), an on-block incrementer, conditional branch and wait modes, and a microsubroutine return stack.
- Sits between the control-store ROM and the instruction encoder.
- Drives the control-store address every cycle.

Parameters:
- ADDR_W, 8, micro-address width.
- STACK_DEPTH, 4, return-stack entries (>=1).
- RESET_ADDR, 0, uPC value after reset.
- FETCH_ADDR, 1, address of the fetch microroutine.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- hold  in  1  stall; freezes uPC and stack.
- ns_op  in  4  next-state operation from the current microinstruction.
- cond  in  1  evaluated condition (condition tester / MOC).
- cr_addr  in  ADDR_W  branch target field of the microinstruction.
- enc_addr  in  ADDR_W  microroutine start address from the instruction encoder.
- next_addr  out  ADDR_W  combinational next address; feeds control-store address.
- upc  out  ADDR_W  registered current micro-address.
- sp  out  clog2(STACK_DEPTH+1)  stack occupancy.
- err_ovf  out  1  sticky: push attempted while stack full.
- err_unf  out  1  sticky: pop attempted while stack empty.
- err_op  out  1  sticky: undefined ns_op executed.

Behaviour:
- Definitions:
  - inc = upc+1, modulo 2^ADDR_W; the all-ones address wraps to 0 with no flag.
  - next_addr is combinational from the current inputs and state.
  - upc <= next_addr on each clk edge when hold=0 and reset=0.
- ns_op decode (next_addr, stack action):
  - 0 ENC: enc_addr.
  - 1 FETCH: FETCH_ADDR.
  - 2 JMP: cr_addr.
  - 3 INC: inc.
  - 4 CJMP: cond ? cr_addr : inc.
  - 5 CJMPN: cond ? inc : cr_addr.
  - 6 CENC: cond ? enc_addr : inc.
  - 7 CFETCH: cond ? FETCH_ADDR : inc.
  - 8 CALL: cr_addr; push inc.
  - 9 CCALL: cond ? (cr_addr, push inc) : inc.
  - 10 RET: top of stack; pop.
  - 11 CRET: cond ? (top, pop) : inc.
  - 12 WAIT: cond ? inc : upc (self-loop until cond, e.g. memory MOC).
  - 13-15: treated as INC; set err_op.
- Stack:
  - LIFO of STACK_DEPTH entries; sp counts 0..STACK_DEPTH.
  - Push when sp==STACK_DEPTH: entry discarded, sp unchanged, err_ovf set, branch still taken.
  - Pop when sp==0: next_addr = FETCH_ADDR, sp stays 0, err_unf set.
  - Only one stack action per cycle.
- hold=1:
  - upc, sp, stack contents and error flags all unchanged.
  - next_addr still reflects the decode, so the ROM sees a stable address.
- Reset: synchronous, active-high, overrides hold.
  - upc=RESET_ADDR; sp=0; err_ovf=err_unf=err_op=0.
  - next_addr is combinational and follows the decode of the reset-state upc.
  - Reset mid-subroutine discards all stack entries.
- Error flags:
  - Set only on a non-held, non-reset edge.
  - Cleared only by reset.
- Latency:
  - One cycle from ns_op/cond valid to upc update.
  - No internal pipelining; the cond sample is the value present at the edge.

Test Plan:
- Reset then idle:
  - reset=1 for 2 clk, then ns_op=INC for 3 clk.
  - Required: upc 0 -> 1 -> 2 -> 3; sp=0; all errors 0.
- Conditional branch:
  - upc=5, cr_addr=0x40, ns_op=CJMP.
  - cond=1 -> upc=0x40.
  - Repeat from upc=5 with cond=0 -> upc=6.
  - CJMPN with cond=0 -> upc=0x40.
- Call/return nesting:
  - From upc=0x10, CALL 0x80; at 0x80, CALL 0x90; at 0x90, RET; then RET.
  - Required upc sequence: 0x80, 0x90, 0x81, 0x11.
  - Required sp sequence: 1, 2, 1, 0.
- Stack boundaries (STACK_DEPTH=4):
  - 5 consecutive CALLs -> sp=4, err_ovf=1, fifth target still taken.
  - Then 5 RETs -> fifth RET gives upc=FETCH_ADDR, err_unf=1, sp=0.
- WAIT and hold:
  - ns_op=WAIT at upc=0x22 with cond=0 for 3 clk -> upc stays 0x22.
  - Then cond=1 -> upc=0x23.
  - hold=1 during a CALL -> upc and sp unchanged; next_addr=cr_addr.
- Wrap, illegal op and mid-operation reset:
  - upc=0xFF, INC -> upc=0x00, no flag.
  - ns_op=14 -> upc increments and err_op=1.
  - reset with sp=3 and hold=1 -> upc=RESET_ADDR, sp=0, all flags cleared.
